store_buffer: RTL and testbench

Speculative store buffer that accepts completed stores from the load/store execution unit, holds them until the reorder buffer commits them in order, and drains committed stores to data memory one per cycle. Loads read it in parallel with memory so that the youngest matching store forwards its data. Entries are rolled back on branch mispredict and have their speculative bit cleared on a correct prediction. It sits between the load/store execution unit, the ROB commit path and the data-memory write port.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer_fwd_search.sv | 22 ++
 rtl/store_buffer.sv | 157 +++++++++++++++
 tb/tb_store_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer slice.
// SB_ENTRY_NUM/SB_ENTRY_SEL size the buffer; DATA_LEN/ADDR_LEN/SPECTAG_LEN are core-wide widths.
package store_buffer_pkg;

    localparam int DATA_LEN     = 32;
    localparam int ADDR_LEN     = 32;
    localparam int SPECTAG_LEN  = 5;
    localparam int SB_ENTRY_NUM = 32;
    localparam int SB_ENTRY_SEL = 5;
    localparam int SB_CNT_W     = SB_ENTRY_SEL + 1;

    typedef logic [SB_ENTRY_SEL-1:0] sb_ptr_t;
    typedef logic [SB_CNT_W-1:0]     sb_cnt_t;

    localparam sb_cnt_t SB_FULL_CNT = sb_cnt_t'(SB_ENTRY_NUM);

    function automatic sb_ptr_t ptr_inc(input sb_ptr_t p);
        return p + sb_ptr_t'(1);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Signal bundle between the store buffer and the LSU, ROB commit path and dmem write port.
interface store_buffer_if;
    import store_buffer_pkg::*;

    // stfin is a push accepted only while fullsb is low; dmem_we is a push the
    // memory port always accepts, so there is no ready in either direction.
    logic                   prmiss;
    logic                   prsuccess;
    logic [SPECTAG_LEN-1:0] spectagfix;
    logic                   stfin;
    logic                   specbit;
    logic [SPECTAG_LEN-1:0] spectag;
    logic [ADDR_LEN-1:0]    storeaddr;
    logic [DATA_LEN-1:0]    storedata;
    logic                   fullsb;
    logic                   stcommit;
    logic [ADDR_LEN-1:0]    ldaddr;
    logic                   hitsb;
    logic [DATA_LEN-1:0]    lddatasb;
    logic                   memoccupy_ld;
    logic                   dmem_we;
    logic [ADDR_LEN-1:0]    dmem_waddr;
    logic [DATA_LEN-1:0]    dmem_wdata;

    modport master (
        output prmiss, prsuccess, spectagfix, stfin, specbit, spectag,
               storeaddr, storedata, stcommit, ldaddr, memoccupy_ld,
        input  fullsb, hitsb, lddatasb, dmem_we, dmem_waddr, dmem_wdata
    );

    modport slave (
        input  prmiss, prsuccess, spectagfix, stfin, specbit, spectag,
               storeaddr, storedata, stcommit, ldaddr, memoccupy_ld,
        output fullsb, hitsb, lddatasb, dmem_we, dmem_waddr, dmem_wdata
    );

endinterface

// File: rtl/store_buffer_fwd_search.sv
// Youngest-match finder for load forwarding: scans backwards from tail-1 around the ring.
module sb_fwd_search
    import store_buffer_pkg::*;
(
    input  logic [SB_ENTRY_NUM-1:0] match_i,
    input  sb_ptr_t                 tail_i,
    output sb_ptr_t                 idx_o,
    output logic                    hit_o
);

    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < SB_ENTRY_NUM; i++) begin
            if (!hit_o && match_i[tail_i - sb_ptr_t'(i + 1)]) begin
                hit_o = 1'b1;
                idx_o = tail_i - sb_ptr_t'(i + 1);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Speculative store buffer: allocate, in-order commit, one-per-cycle drain, forwarding, rollback.
// Optional STOREBUF_STATS_EN adds stat_retired / stat_fullcyc counters.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
`ifdef STOREBUF_STATS_EN
    ,
    output logic [31:0]   stat_retired,
    output logic [31:0]   stat_fullcyc
`endif
);

    logic [SB_ENTRY_NUM-1:0] valid_q, valid_d;
    logic [SB_ENTRY_NUM-1:0] committed_q, committed_d;
    logic [SB_ENTRY_NUM-1:0] specbit_q, specbit_d;
    logic [SPECTAG_LEN-1:0]  spectag_q [SB_ENTRY_NUM];
    logic [ADDR_LEN-1:0]     addr_q    [SB_ENTRY_NUM];
    logic [DATA_LEN-1:0]     data_q    [SB_ENTRY_NUM];

    sb_ptr_t head_q, head_d;
    sb_ptr_t tail_q, tail_d;
    sb_ptr_t comptr_q, comptr_d;
    sb_cnt_t count_q, count_d;

    logic                    full;
    logic                    alloc;
    logic                    retire;
    logic [SB_ENTRY_NUM-1:0] tag_match;
    logic [SB_ENTRY_NUM-1:0] kill_vec;
    logic [SB_ENTRY_NUM-1:0] ld_match;
    logic                    kill_any;
    sb_ptr_t                 kill_idx;
    sb_cnt_t                 kill_cnt;
    sb_ptr_t                 alloc_idx;
    sb_ptr_t                 fwd_idx;
    logic                    fwd_hit;

    assign full   = (count_q == SB_FULL_CNT);
    assign alloc  = sb.stfin & ~full;
    assign retire = valid_q[head_q] & committed_q[head_q] & ~sb.memoccupy_ld;

    always_comb begin
        tag_match = '0;
        ld_match  = '0;
        for (int i = 0; i < SB_ENTRY_NUM; i++) begin
            tag_match[i] = |(spectag_q[i] & sb.spectagfix);
            ld_match[i]  = valid_q[i] & (addr_q[i] == sb.ldaddr);
        end
    end

    assign kill_vec = {SB_ENTRY_NUM{sb.prmiss}} & valid_q & ~committed_q & specbit_q & tag_match;

    // Killed entries are a contiguous youngest suffix, so the first one found
    // scanning forward from comptr is where the tail rolls back to.
    always_comb begin
        kill_any = 1'b0;
        kill_idx = comptr_q;
        kill_cnt = '0;
        for (int i = 0; i < SB_ENTRY_NUM; i++) begin
            if (!kill_any && kill_vec[comptr_q + sb_ptr_t'(i)]) begin
                kill_any = 1'b1;
                kill_idx = comptr_q + sb_ptr_t'(i);
            end
            kill_cnt = kill_cnt + sb_cnt_t'(kill_vec[i]);
        end
    end

    assign alloc_idx = kill_any ? kill_idx : tail_q;

    always_comb begin
        head_d      = retire ? ptr_inc(head_q) : head_q;
        comptr_d    = sb.stcommit ? ptr_inc(comptr_q) : comptr_q;
        tail_d      = alloc ? ptr_inc(alloc_idx) : alloc_idx;
        count_d     = count_q + sb_cnt_t'(alloc) - sb_cnt_t'(retire) - kill_cnt;
        valid_d     = valid_q & ~kill_vec;
        committed_d = committed_q;
        specbit_d   = specbit_q;
        if (sb.prsuccess) begin
            specbit_d = specbit_q & ~(valid_q & tag_match);
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
        end
        if (sb.stcommit) begin
            committed_d[comptr_q] = 1'b1;
        end
        if (alloc) begin
            valid_d[alloc_idx]     = 1'b1;
            committed_d[alloc_idx] = 1'b0;
            specbit_d[alloc_idx]   = sb.specbit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            committed_q <= '0;
            specbit_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            comptr_q    <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            specbit_q   <= specbit_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            comptr_q    <= comptr_d;
            count_q     <= count_d;
        end
    end

    // Payload needs no reset: every consumer is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (alloc) begin
            spectag_q[alloc_idx] <= sb.spectag;
            addr_q[alloc_idx]    <= sb.storeaddr;
            data_q[alloc_idx]    <= sb.storedata;
        end
    end

    sb_fwd_search u_fwd (
        .match_i (ld_match),
        .tail_i  (tail_q),
        .idx_o   (fwd_idx),
        .hit_o   (fwd_hit)
    );

    assign sb.fullsb     = full;
    assign sb.hitsb      = fwd_hit;
    assign sb.lddatasb   = fwd_hit ? data_q[fwd_idx] : '0;
    assign sb.dmem_we    = retire;
    assign sb.dmem_waddr = addr_q[head_q];
    assign sb.dmem_wdata = data_q[head_q];

`ifdef STOREBUF_STATS_EN
    logic [31:0] stat_retired_q, stat_fullcyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_retired_q <= '0;
            stat_fullcyc_q <= '0;
        end else begin
            stat_retired_q <= stat_retired_q + 32'(retire);
            stat_fullcyc_q <= stat_fullcyc_q + 32'(full);
        end
    end

    assign stat_retired = stat_retired_q;
    assign stat_fullcyc = stat_fullcyc_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: reference queue of entries plus a dmem write scoreboard.
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct {
        logic [ADDR_LEN-1:0]    addr;
        logic [DATA_LEN-1:0]    data;
        logic                   spec;
        logic [SPECTAG_LEN-1:0] tag;
        logic                   committed;
    } ment_t;

    logic clk = 1'b0;
    logic reset;
    store_buffer_if sb_if();

`ifdef STOREBUF_STATS_EN
    logic [31:0] stat_retired, stat_fullcyc;
`endif

    store_buffer dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
`ifdef STOREBUF_STATS_EN
        ,
        .stat_retired (stat_retired),
        .stat_fullcyc (stat_fullcyc)
`endif
    );

    always #10 clk = ~clk;

    ment_t                        m_q[$];
    logic [ADDR_LEN+DATA_LEN-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int pend_idx = -1;
    int n_retired = 0;
    int n_fullcyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_if.stfin      = 1'b0;
        sb_if.stcommit   = 1'b0;
        sb_if.prmiss     = 1'b0;
        sb_if.prsuccess  = 1'b0;
        sb_if.spectagfix = '0;
        pend_idx = -1;
        if (m_q.size() == SB_ENTRY_NUM) n_fullcyc++;
    endtask

    task automatic set_store(input logic [ADDR_LEN-1:0] a, input logic [DATA_LEN-1:0] d,
                             input logic spec, input logic [SPECTAG_LEN-1:0] tag);
        ment_t e;
        assert (m_q.size() < SB_ENTRY_NUM) else $error("stfin driven while buffer full");
        sb_if.stfin     = 1'b1;
        sb_if.storeaddr = a;
        sb_if.storedata = d;
        sb_if.specbit   = spec;
        sb_if.spectag   = tag;
        e.addr = a; e.data = d; e.spec = spec; e.tag = tag; e.committed = 1'b0;
        m_q.push_back(e);
    endtask

    task automatic set_commit();
        int idx;
        ment_t e;
        idx = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (idx < 0 && !m_q[i].committed) idx = i;
        end
        assert (idx >= 0) else $error("stcommit with no valid uncommitted entry");
        if (idx >= 0) begin
            sb_if.stcommit = 1'b1;
            e = m_q[idx];
            e.committed = 1'b1;
            m_q[idx] = e;
            pend_idx = idx;
            exp_q.push_back({e.addr, e.data});
        end
    endtask

    task automatic set_miss(input logic [SPECTAG_LEN-1:0] fix);
        ment_t keep[$];
        sb_if.prmiss     = 1'b1;
        sb_if.spectagfix = fix;
        foreach (m_q[i]) begin
            if (!(!m_q[i].committed && m_q[i].spec && |(m_q[i].tag & fix))) keep.push_back(m_q[i]);
        end
        m_q = keep;
    endtask

    task automatic set_succ(input logic [SPECTAG_LEN-1:0] fix);
        ment_t e;
        sb_if.prsuccess  = 1'b1;
        sb_if.spectagfix = fix;
        foreach (m_q[i]) begin
            if (|(m_q[i].tag & fix)) begin
                e = m_q[i];
                e.spec = 1'b0;
                m_q[i] = e;
            end
        end
    endtask

    task automatic chk_fwd(input string tag, input logic [ADDR_LEN-1:0] a);
        logic                exp_hit;
        logic [DATA_LEN-1:0] exp_d;
        exp_hit = 1'b0;
        exp_d   = '0;
        sb_if.ldaddr = a;
        #1;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!exp_hit && m_q[i].addr == a) begin
                exp_hit = 1'b1;
                exp_d   = m_q[i].data;
            end
        end
        check_eq({tag, "_hit"}, sb_if.hitsb, exp_hit);
        check_eq({tag, "_data"}, sb_if.lddatasb, exp_d);
    endtask

    task automatic chk_full(input string tag);
        check_eq(tag, sb_if.fullsb, m_q.size() == SB_ENTRY_NUM);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic commit_all();
        int guard;
        guard = 0;
        while (m_q.size() > 0 && !m_q[m_q.size() - 1].committed && guard < 64) begin
            set_commit();
            tick();
            guard++;
        end
    endtask

    // Retire monitor: dmem_we and write payload scored against the commit order.
    always @(negedge clk) begin
        logic exp_we;
        logic [ADDR_LEN+DATA_LEN-1:0] e;
        if (!reset) begin
            exp_we = (m_q.size() > 0) && m_q[0].committed && (pend_idx != 0) && !sb_if.memoccupy_ld;
            check_eq("dmem_we", sb_if.dmem_we, exp_we);
            if (sb_if.dmem_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("dmem_unexpected", sb_if.dmem_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("dmem_wr", {sb_if.dmem_waddr, sb_if.dmem_wdata}, e);
                    n_retired++;
                    if (m_q.size() > 0) void'(m_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [SPECTAG_LEN-1:0] br_tag;
        int sz0;
        bit missed;
        int oldest;

        reset = 1'b1;
        sb_if.prmiss = 0; sb_if.prsuccess = 0; sb_if.spectagfix = '0;
        sb_if.stfin = 0; sb_if.specbit = 0; sb_if.spectag = '0;
        sb_if.storeaddr = '0; sb_if.storedata = '0; sb_if.stcommit = 0;
        sb_if.ldaddr = '0; sb_if.memoccupy_ld = 0;

        // Reset values
        tick(); tick();
        sb_if.ldaddr = 32'h100;
        #1;
        check_eq("rst_full", sb_if.fullsb, 1'b0);
        check_eq("rst_hit", sb_if.hitsb, 1'b0);
        check_eq("rst_data", sb_if.lddatasb, 32'h0);
        check_eq("rst_we", sb_if.dmem_we, 1'b0);
        reset = 1'b0;
        n_fullcyc = 0;

        // First store forwards from the next cycle only
        set_store(32'h100, 32'hAA, 1'b0, '0);
        #1;
        check_eq("fwd_same_cycle_hit", sb_if.hitsb, 1'b0);
        tick();
        chk_fwd("fwd_first", 32'h100);
        check_eq("fwd_first_data", sb_if.lddatasb, 32'hAA);
        chk_full("full_after_one");

        // Youngest matching store wins
        set_store(32'h200, 32'h1, 1'b0, '0); tick();
        set_store(32'h200, 32'h2, 1'b0, '0); tick();
        chk_fwd("youngest", 32'h200);
        check_eq("youngest_data", sb_if.lddatasb, 32'h2);

        // Commit to memory at the earliest one cycle later
        set_commit();
        #1;
        check_eq("we_same_cycle", sb_if.dmem_we, 1'b0);
        tick();
        check_eq("we_next_cycle", sb_if.dmem_we, 1'b1);
        commit_all();
        wait_drain(10);

        // Fill to full, then free one slot
        for (int i = 0; i < SB_ENTRY_NUM; i++) begin
            set_store(32'h1000 + 32'($urandom_range(0, 15)) * 4, $urandom, 1'b0, '0);
            tick();
            chk_full("fill_full");
            chk_fwd("fill_fwd", 32'h1000 + 32'($urandom_range(0, 15)) * 4);
        end
        check_eq("full_flag", sb_if.fullsb, 1'b1);
        set_commit();
        tick();
        check_eq("full_we", sb_if.dmem_we, 1'b1);
        chk_full("full_still");
        tick();
        check_eq("full_drop", sb_if.fullsb, 1'b0);
        commit_all();
        wait_drain(40);

        // Mispredict rolls back three speculative stores
        set_store(32'h400, 32'h44, 1'b0, '0); tick();
        for (int k = 0; k < 3; k++) begin
            set_store(32'h500 + 32'(k) * 4, 32'h50 + 32'(k), 1'b1, 5'b00010);
            tick();
        end
        chk_fwd("pre_kill", 32'h504);
        set_miss(5'b00010);
        tick();
        for (int k = 0; k < 3; k++) chk_fwd("killed", 32'h500 + 32'(k) * 4);
        check_eq("killed_hit", sb_if.hitsb, 1'b0);
        set_store(32'h600, 32'h66, 1'b0, '0); tick();
        commit_all();
        wait_drain(10);

        // Allocation in the same cycle as a kill lands at the rolled-back slot
        set_store(32'h700, 32'h70, 1'b1, 5'b00010); tick();
        set_store(32'h704, 32'h74, 1'b1, 5'b00010); tick();
        set_miss(5'b00010);
        set_store(32'h710, 32'h71, 1'b0, '0);
        tick();
        chk_fwd("alloc_on_kill", 32'h710);
        chk_fwd("alloc_on_kill_gone", 32'h700);
        commit_all();
        wait_drain(10);

        // Load owning the port stalls retire without losing data
        set_store(32'h800, 32'h88, 1'b0, '0); tick();
        sb_if.memoccupy_ld = 1'b1;
        set_commit();
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("we_stall", sb_if.dmem_we, 1'b0);
            tick();
        end
        sb_if.memoccupy_ld = 1'b0;
        #1;
        check_eq("we_release", sb_if.dmem_we, 1'b1);
        check_eq("wdata_release", sb_if.dmem_wdata, 32'h88);
        tick();
        wait_drain(10);

        // Correct prediction clears specbit so a later mispredict spares the entry
        set_store(32'h900, 32'h99, 1'b1, 5'b00100); tick();
        set_succ(5'b00100); tick();
        set_miss(5'b00100); tick();
        chk_fwd("survive", 32'h900);
        check_eq("survive_hit", sb_if.hitsb, 1'b1);
        commit_all();
        wait_drain(10);

        // Reset mid-operation drops committed-but-unretired stores too
        set_store(32'hA00, 32'hA0, 1'b0, '0); tick();
        set_store(32'hA04, 32'hA4, 1'b0, '0); tick();
        sb_if.memoccupy_ld = 1'b1;
        set_commit();
        tick();
        reset = 1'b1;
        tick();
        m_q.delete();
        exp_q.delete();
        n_retired = 0;
        n_fullcyc = 0;
        reset = 1'b0;
        sb_if.memoccupy_ld = 1'b0;
        chk_fwd("midrst", 32'hA00);
        check_eq("midrst_we", sb_if.dmem_we, 1'b0);
        chk_full("midrst_full");

        // Random mixed traffic with at most one outstanding branch
        br_tag = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk_fwd("rnd", 32'h2000 + 32'($urandom_range(0, 7)) * 4);
            chk_full("rnd_full");
            sb_if.memoccupy_ld = ($urandom_range(0, 3) == 0);
            sz0 = m_q.size();
            missed = 1'b0;
            if (br_tag != '0 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_miss(br_tag);
                    missed = 1'b1;
                end else begin
                    set_succ(br_tag);
                end
                br_tag = '0;
            end else if (br_tag == '0 && $urandom_range(0, 7) == 0) begin
                br_tag = SPECTAG_LEN'(1) << $urandom_range(0, SPECTAG_LEN - 1);
            end
            oldest = -1;
            for (int i = 0; i < m_q.size(); i++) begin
                if (oldest < 0 && !m_q[i].committed) oldest = i;
            end
            if (!missed && oldest >= 0 && $urandom_range(0, 1) == 1) begin
                if (!m_q[oldest].spec) set_commit();
            end
            if (sz0 < SB_ENTRY_NUM && $urandom_range(0, 2) != 0) begin
                set_store(32'h2000 + 32'($urandom_range(0, 7)) * 4, $urandom,
                          br_tag != '0, br_tag);
            end
            tick();
        end
        sb_if.memoccupy_ld = 1'b0;
        if (br_tag != '0) begin
            set_succ(br_tag);
            tick();
        end
        commit_all();
        wait_drain(100);
        tick();
        chk_full("end_full");
        chk_fwd("end_empty", 32'h2000);
`ifdef STOREBUF_STATS_EN
        check_eq("stat_retired", stat_retired, 64'(n_retired));
        check_eq("stat_fullcyc", stat_fullcyc, 64'(n_fullcyc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
